// File: rtl/spi_slave_pkg.sv
// Shared types for the system-clock SPI slave: FSM states, SPI mode encoding
// and the helpers that map a mode onto its sample and shift edges.
package spi_slave_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_slv_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

   // cpha=0 samples on the leading edge, cpha=1 on the trailing edge.
   function automatic logic is_sample_edge(input spi_mode_t m, input logic lead, input logic trail);
      return m.cpha ? trail : lead;
   endfunction

   function automatic logic is_shift_edge(input spi_mode_t m, input logic lead, input logic trail);
      return m.cpha ? lead : trail;
   endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronisers for the SPI pins plus edge pulses on the synced
// values; lead/trail are classified against the current clock polarity.
module spi_slave_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic cpol_i,
   input  logic spi_clk_i,
   input  logic spi_mosi_i,
   input  logic spi_ss_n_i,
   output logic mosi_o,
   output logic lead_o,
   output logic trail_o,
   output logic ss_fall_o,
   output logic ss_rise_o
);

   // bit 2 = spi_clk, bit 1 = spi_mosi, bit 0 = spi_ss_n
   logic [2:0] meta_q;
   logic [2:0] sync_q;
   logic [1:0] prev_q;
   logic       sclk_chg;

   // ss_n stages come out of reset deselected so no false frame start is seen.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= 3'b001;
         sync_q <= 3'b001;
         prev_q <= 2'b01;
      end else begin
         meta_q <= {spi_clk_i, spi_mosi_i, spi_ss_n_i};
         sync_q <= meta_q;
         prev_q <= {sync_q[2], sync_q[0]};
      end
   end

   assign sclk_chg  = sync_q[2] ^ prev_q[1];
   assign mosi_o    = sync_q[1];
   assign lead_o    = sclk_chg & (sync_q[2] != cpol_i);
   assign trail_o   = sclk_chg & (sync_q[2] == cpol_i);
   assign ss_fall_o = prev_q[0] & ~sync_q[0];
   assign ss_rise_o = ~prev_q[0] & sync_q[0];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave oversampled on clk with rx/tx valid-ready streams.
// Optional SPI_SLAVE_LSB_FIRST_EN adds an lsb_first input for LSB-first frames.
//
// state | meaning
// IDLE  | deselected, miso not driven, waiting for ss_n fall
// SHIFT | frame in progress, miso driven, counting sample edges
module spi_slave_core
   import spi_slave_pkg::*;
#(
   parameter int                DATA_W  = 8,
   parameter logic [DATA_W-1:0] TX_IDLE = 'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   input  logic              spi_ss_n,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              frame_err
`ifdef SPI_SLAVE_LSB_FIRST_EN
   ,
   input  logic              lsb_first
`endif
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   spi_slv_state_t    state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
   logic              tx_full_q, tx_full_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              overrun_q, overrun_d;
   logic              frame_err_q, frame_err_d;
   logic              miso_q, miso_d;

   logic              mosi_s, lead_s, trail_s, ss_fall_s, ss_rise_s;
   logic              sample_e, shift_e, lsb_sel;
   spi_mode_t         mode;
   logic [DATA_W-1:0] tx_next_word, rx_shifted;

   spi_slave_sync u_sync (
      .clk_i      (clk),
      .reset_i    (reset),
      .cpol_i     (cpol),
      .spi_clk_i  (spi_clk),
      .spi_mosi_i (spi_mosi),
      .spi_ss_n_i (spi_ss_n),
      .mosi_o     (mosi_s),
      .lead_o     (lead_s),
      .trail_o    (trail_s),
      .ss_fall_o  (ss_fall_s),
      .ss_rise_o  (ss_rise_s)
   );

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign lsb_sel = lsb_first;
`else
   assign lsb_sel = 1'b0;
`endif

   assign mode         = '{cpol: cpol, cpha: cpha};
   assign sample_e     = is_sample_edge(mode, lead_s, trail_s);
   assign shift_e      = is_shift_edge(mode, lead_s, trail_s);
   assign tx_next_word = tx_full_q ? tx_buf_q : TX_IDLE;
   assign rx_shifted   = lsb_sel ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                                 : {rx_shift_q[DATA_W-2:0], mosi_s};

   function automatic logic pop_bit(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? w[0] : w[DATA_W-1];
   endfunction

   function automatic logic [DATA_W-1:0] pop_word(input logic [DATA_W-1:0] w, input logic lsb);
      return lsb ? (w >> 1) : (w << 1);
   endfunction

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      tx_buf_d    = tx_buf_q;
      tx_full_d   = tx_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      frame_err_d = 1'b0;
      miso_d      = miso_q;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      // Accept only into an empty buffer, loads only drain a full one: never both.
      if (tx_valid && !tx_full_q) begin
         tx_buf_d  = tx_data;
         tx_full_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (ss_fall_s) begin
               state_d    = SHIFT;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               if (tx_full_q) begin
                  tx_full_d = 1'b0;
               end
               if (!cpha) begin
                  miso_d     = pop_bit(tx_next_word, lsb_sel);
                  tx_shift_d = pop_word(tx_next_word, lsb_sel);
               end else begin
                  tx_shift_d = tx_next_word;
               end
            end
         end

         SHIFT: begin
            if (ss_rise_s) begin
               state_d     = IDLE;
               bit_cnt_d   = '0;
               miso_d      = 1'b0;
               frame_err_d = (bit_cnt_q != '0);
            end else begin
               // Every shift edge pops the next bit, so cpha=1's first leading
               // edge naturally presents the first bit of the freshly loaded word.
               if (shift_e) begin
                  miso_d     = pop_bit(tx_shift_q, lsb_sel);
                  tx_shift_d = pop_word(tx_shift_q, lsb_sel);
               end
               if (sample_e) begin
                  rx_shift_d = rx_shifted;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_d  = '0;
                     tx_shift_d = tx_next_word;
                     if (tx_full_q) begin
                        tx_full_d = 1'b0;
                     end
                     if (rx_valid_q && !rx_ready) begin
                        overrun_d = 1'b1;
                     end else begin
                        rx_data_d  = rx_shifted;
                        rx_valid_d = 1'b1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         tx_buf_q    <= '0;
         tx_full_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         miso_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         tx_buf_q    <= tx_buf_d;
         tx_full_q   <= tx_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         miso_q      <= miso_d;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = (state_q == SHIFT);
   assign tx_ready    = ~tx_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_overrun  = overrun_q;
   assign frame_err   = frame_err_q;

endmodule
